useq: RTL

- Parametrised microcode sequencer for the next CPU generation. It replaces the fixed 3-bit T-state counter, decode and jump-flag glue with a single block.
- It generates the microcode ROM address from the opcode and T-state, and gates the returned microinstruction onto the control lines.
- It holds the ALU flag register, evaluates jump conditions, and adds three behaviours the current core lacks: memory wait-state stalls, halt/resume, and interrupt entry at instruction boundaries.
- It sits between the IR/ALU datapath and an external combinational microcode ROM.

---
 rtl/useq_pkg.sv | 23 ++
 rtl/useq_jump.sv | 18 +
 rtl/useq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/useq_pkg.sv
// Shared types and defaults for the microcode sequencer and its jump evaluator.
package useq_pkg;

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  localparam int DEF_RT_BIT   = 0;
  localparam int DEF_MEM_BIT  = 1;
  localparam int DEF_HALT_BIT = 2;
  localparam int DEF_JBASE    = 3;

  // Jump-condition field as it sits in the microinstruction, MSB first.
  typedef struct packed {
    logic jgt;
    logic jlt;
    logic jz;
    logic jc;
  } jcond_t;

  function automatic int t_bits(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/useq_jump.sv
// Combinational jump-condition evaluator: J field and {C,Z,LT} flags to a raw take signal.
module useq_jump
  import useq_pkg::*;
(
  input  jcond_t     jc,
  input  logic [2:0] flags,
  output logic       jmp
);

  logic c, z, lt;

  assign c  = flags[2];
  assign z  = flags[1];
  assign lt = flags[0];

  assign jmp = (jc.jc & c) | (jc.jz & z) | (jc.jlt & lt) | (jc.jgt & ~z & ~lt);

endmodule

// File: rtl/useq.sv
// Microcode sequencer: T-state counter, ROM addressing, control gating, flags,
// jumps, memory wait states, halt/resume and interrupt entry at instruction boundaries.
module useq
  import useq_pkg::*;
#(
  parameter int                OPBITS     = 8,
  parameter int                TSTATES    = 8,
  parameter int                UWIDTH     = 24,
  parameter int                RT_BIT     = DEF_RT_BIT,
  parameter int                MEM_BIT    = DEF_MEM_BIT,
  parameter int                HALT_BIT   = DEF_HALT_BIT,
  parameter int                JBASE      = DEF_JBASE,
  parameter logic [UWIDTH-1:0] STALL_MASK = 24'h0000F1,
  parameter logic [OPBITS-1:0] IRQ_OPCODE = 8'hFF,
  localparam int               TBITS      = t_bits(TSTATES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPBITS-1:0]       ir_opcode,
  output logic [OPBITS+TBITS-1:0] uaddr,
  input  logic [UWIDTH-1:0]       uinstr,
  output logic [UWIDTH-1:0]       ctrl,
  output logic [TBITS-1:0]        T,
  input  logic [2:0]              flags_in,
  input  logic                    flags_we,
  output logic [2:0]              flags,
  output logic                    jmp,
  input  logic                    mem_rdy,
  input  logic                    irq,
  input  logic                    irq_en,
  output logic                    irq_ack,
  input  logic                    run,
  output logic                    halted
);

  state_t            state, state_nx;
  logic [TBITS-1:0]  t_q, t_nx;
  logic [2:0]        flags_q, flags_nx;
  logic              in_irq, in_irq_nx, ack_nx;
  logic              active, stall, go, boundary, take_irq, jraw;
  logic [OPBITS-1:0] opcode_sel;
  jcond_t            jfield;

  assign active     = (state != HALT);
  assign stall      = uinstr[MEM_BIT] & ~mem_rdy;
  // WAIT with memory ready behaves exactly like an unstalled RUN cycle.
  assign go         = active & ~stall;
  assign boundary   = uinstr[RT_BIT] | (t_q == TBITS'(TSTATES - 1));
  assign take_irq   = irq & irq_en;
  assign opcode_sel = in_irq ? IRQ_OPCODE : ir_opcode;

  assign uaddr   = {opcode_sel, t_q};
  assign T       = t_q;
  assign flags   = flags_q;
  assign halted  = (state == HALT);

  assign jfield = jcond_t'(uinstr[JBASE+3:JBASE]);

  useq_jump u_jump (
    .jc    (jfield),
    .flags (flags_q),
    .jmp   (jraw)
  );

  assign jmp = go & jraw;

  always_comb begin
    ctrl = uinstr;
    if (state == HALT)  ctrl = '0;
    else if (stall)     ctrl = uinstr & ~STALL_MASK;
  end

  always_comb begin
    state_nx  = state;
    t_nx      = t_q;
    flags_nx  = flags_q;
    in_irq_nx = in_irq;
    ack_nx    = 1'b0;
    case (state)
      HALT: begin
        if (take_irq) begin
          state_nx  = RUN;
          in_irq_nx = 1'b1;
          ack_nx    = 1'b1;
        end else if (run) begin
          state_nx = RUN;
        end
      end
      default: begin
        if (stall) begin
          state_nx = WAIT;
        end else begin
          state_nx = RUN;
          if (flags_we) flags_nx = flags_in;
          if (uinstr[HALT_BIT]) begin
            // Halting ends the current instruction, including a handler.
            state_nx  = HALT;
            t_nx      = '0;
            in_irq_nx = 1'b0;
          end else if (boundary) begin
            t_nx = '0;
            // Leaving a handler never re-enters on the same boundary.
            if (in_irq) begin
              in_irq_nx = 1'b0;
            end else if (take_irq) begin
              in_irq_nx = 1'b1;
              ack_nx    = 1'b1;
            end
          end else begin
            t_nx = t_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      t_q     <= '0;
      flags_q <= '0;
      in_irq  <= 1'b0;
      irq_ack <= 1'b0;
    end else begin
      state   <= state_nx;
      t_q     <= t_nx;
      flags_q <= flags_nx;
      in_irq  <= in_irq_nx;
      irq_ack <= ack_nx;
    end
  end

endmodule
